// File: rtl/mips_fetch_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_fetch_fetch
// Brief    : Instruction fetch stage with credit-limited issue, in-flight
//            address tracking, redirect flush and an instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
module mips_fetch_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_pc_addr,
    input  logic              i_redirect,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    input  logic              i_mem_rsp_valid,
    input  logic [DATA_W-1:0] i_mem_rsp_data,
    output logic              o_pc_stall,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst_data,
    output logic [ADDR_W-1:0] o_inst_addr,
    input  logic              i_inst_ready
);

    localparam int               c_cnt_w = $clog2(DEPTH + 1);
    localparam int               c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    logic [c_cnt_w-1:0] r_live;
    logic [c_cnt_w-1:0] r_discard;
    logic [c_cnt_w-1:0] r_occ;

    logic [c_ptr_w-1:0] r_af_wp;
    logic [c_ptr_w-1:0] r_af_rp;
    logic [c_ptr_w-1:0] r_iq_wp;
    logic [c_ptr_w-1:0] r_iq_rp;

    logic [ADDR_W-1:0]  r_af_mem  [DEPTH];
    logic [ADDR_W-1:0]  r_iq_addr [DEPTH];
    logic [DATA_W-1:0]  r_iq_data [DEPTH];

    logic [c_cnt_w:0]   w_credit_used;
    logic               w_issue;
    logic               w_rsp;
    logic               w_drop;
    logic               w_push;
    logic               w_deq;
    logic [c_cnt_w-1:0] w_live_nxt;
    logic [c_cnt_w-1:0] w_discard_nxt;
    logic [c_cnt_w-1:0] w_occ_nxt;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Queued entries stop counting against credit on a redirect: the queue is flushed at this edge.
    assign w_credit_used = {1'b0, r_live} + {1'b0, r_discard}
                         + (i_redirect ? '0 : {1'b0, r_occ});

    assign o_mem_req_valid = !rst && (w_credit_used < c_depth);
    assign o_mem_req_addr  = i_pc_addr;
    assign w_issue         = o_mem_req_valid && i_mem_req_ready;
    assign o_pc_stall      = !w_issue;

    assign w_rsp  = i_mem_rsp_valid && ((r_live != '0) || (r_discard != '0));
    assign w_drop = i_redirect || (r_discard != '0);
    assign w_push = w_rsp && !w_drop;

    assign o_inst_valid = !rst && (r_occ != '0);
    assign o_inst_addr  = r_iq_addr[r_iq_rp];
    assign o_inst_data  = r_iq_data[r_iq_rp];
    assign w_deq        = o_inst_valid && i_inst_ready;

    always_comb begin
        w_live_nxt    = r_live;
        w_discard_nxt = r_discard;
        w_occ_nxt     = r_occ;
        if (i_redirect) begin
            // Everything in flight becomes old-path; a same-cycle response retires one of them.
            w_live_nxt    = w_issue ? c_cnt_w'(1) : '0;
            w_discard_nxt = r_discard + r_live - c_cnt_w'(w_rsp);
            w_occ_nxt     = '0;
        end else begin
            if (w_rsp) begin
                if (r_discard != '0) begin
                    w_discard_nxt = r_discard - c_cnt_w'(1);
                end else begin
                    w_live_nxt = r_live - c_cnt_w'(1);
                end
            end
            if (w_issue) begin
                w_live_nxt = w_live_nxt + c_cnt_w'(1);
            end
            w_occ_nxt = r_occ + c_cnt_w'(w_push) - c_cnt_w'(w_deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live    <= '0;
            r_discard <= '0;
            r_occ     <= '0;
            r_af_wp   <= '0;
            r_af_rp   <= '0;
            r_iq_wp   <= '0;
            r_iq_rp   <= '0;
        end else begin
            r_live    <= w_live_nxt;
            r_discard <= w_discard_nxt;
            r_occ     <= w_occ_nxt;
            if (w_issue) begin
                r_af_wp <= ptr_inc(r_af_wp);
            end
            if (w_rsp) begin
                r_af_rp <= ptr_inc(r_af_rp);
            end
            if (i_redirect) begin
                r_iq_wp <= '0;
                r_iq_rp <= '0;
            end else begin
                if (w_push) begin
                    r_iq_wp <= ptr_inc(r_iq_wp);
                end
                if (w_deq) begin
                    r_iq_rp <= ptr_inc(r_iq_rp);
                end
            end
        end
    end

    // Storage arrays need no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_af_mem[r_af_wp] <= i_pc_addr;
        end
        if (w_push) begin
            r_iq_addr[r_iq_wp] <= r_af_mem[r_af_rp];
            r_iq_data[r_iq_wp] <= i_mem_rsp_data;
        end
    end

endmodule
`default_nettype wire
